// File: rtl/i2s_pkg.sv
// Shared I2S defaults and types used by the transmit and receive audio blocks.
package i2s_pkg;

    localparam int unsigned SAMPLE_WIDTH_DEF = 24;
    localparam int unsigned SLOT_WIDTH_DEF   = 32;
    localparam int unsigned MCLK_DIV_DEF     = 4;
    localparam int unsigned FRAME_CYCLES_DEF = 2 * SLOT_WIDTH_DEF * MCLK_DIV_DEF;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing base: divides AMCLK down to BCK and tracks the bit position within a stereo frame.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned SLOT_WIDTH = SLOT_WIDTH_DEF,
    parameter int unsigned MCLK_DIV   = MCLK_DIV_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    output logic                            o_sclk,
    output logic [$clog2(2*SLOT_WIDTH)-1:0] o_bit,
    output logic                            o_bck_fall,
    output logic                            o_load,
    output logic                            o_load_pre
);

    localparam int unsigned BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int unsigned DIV_W = $clog2(MCLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(MCLK_DIV - 2);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [BIT_W-1:0] r_bit;
    logic             r_sclk;
    logic             w_bck_fall;
    logic             w_frame_end;

    always_comb begin
        w_div_next  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        w_bck_fall  = (r_div == DIV_LAST);
        w_frame_end = (r_bit == BIT_LAST);
    end

    // ASCLK is registered from the next divider value so it tracks d exactly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_div  <= w_div_next;
            r_sclk <= (w_div_next >= DIV_HALF);
            if (w_bck_fall) begin
                r_bit <= w_frame_end ? '0 : r_bit + 1'b1;
            end
        end
    end

    assign o_sclk     = r_sclk;
    assign o_bit      = r_bit;
    assign o_bck_fall = w_bck_fall;
    assign o_load     = w_bck_fall && w_frame_end;
    assign o_load_pre = (r_div == DIV_PRE) && w_frame_end;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo PCM to Philips I2S transmitter with a single-pair pending register and valid/ready intake.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int unsigned SLOT_WIDTH   = SLOT_WIDTH_DEF,
    parameter int unsigned MCLK_DIV     = MCLK_DIV_DEF
) (
    input  logic                    AMCLK_i,
    input  logic                    nARST,
    input  logic [SAMPLE_WIDTH-1:0] sample_l_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_r_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    output logic                    ASCLK_o,
    output logic                    ALRCLK_o,
    output logic                    ASDATA_o,
    output logic                    frame_start_o,
    output logic                    underrun_o
);

    localparam int unsigned BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);

    logic                    w_sclk;
    logic [BIT_W-1:0]        w_bit;
    logic                    w_bck_fall;
    logic                    w_load;
    logic                    w_load_pre;

    logic [SAMPLE_WIDTH-1:0] r_pend_l;
    logic [SAMPLE_WIDTH-1:0] r_pend_r;
    logic                    r_full;
    logic [SAMPLE_WIDTH-1:0] r_frame_l;
    logic [SAMPLE_WIDTH-1:0] r_frame_r;
    logic                    r_ready;
    i2s_ch_e                 r_lr;
    logic                    r_sdata;
    logic                    r_frame_start;
    logic                    r_underrun;

    logic                    w_accept;
    logic                    w_full_next;
    logic [BIT_W-1:0]        w_bit_next;
    logic                    w_right_next;
    logic [BIT_W-1:0]        w_pos_next;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic                    w_sdata_next;

    i2s_clkgen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .MCLK_DIV   (MCLK_DIV)
    ) u_clkgen (
        .i_clk      (AMCLK_i),
        .i_rst_n    (nARST),
        .o_sclk     (w_sclk),
        .o_bit      (w_bit),
        .o_bck_fall (w_bck_fall),
        .o_load     (w_load),
        .o_load_pre (w_load_pre)
    );

    assign w_accept = sample_valid_i && r_ready;

    always_comb begin
        w_full_next = r_full;
        if (w_load) begin
            w_full_next = w_accept;
        end else if (w_accept) begin
            w_full_next = 1'b1;
        end
    end

    // Serial bit is computed for the bit index that becomes current at the BCK fall;
    // slot position 0 is always 0, so the frame-register swap at load never shows.
    always_comb begin
        w_bit_next   = (w_bit == BIT_LAST) ? '0 : w_bit + 1'b1;
        w_right_next = (w_bit_next >= SLOT_LEN);
        w_pos_next   = w_right_next ? w_bit_next - SLOT_LEN : w_bit_next;
        w_word       = w_right_next ? r_frame_r : r_frame_l;
        w_sdata_next = 1'b0;
        for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
            if (w_pos_next == BIT_W'(SAMPLE_WIDTH - i)) begin
                w_sdata_next = w_word[i];
            end
        end
    end

    always_ff @(posedge AMCLK_i or negedge nARST) begin
        if (!nARST) begin
            r_pend_l      <= '0;
            r_pend_r      <= '0;
            r_full        <= 1'b0;
            r_frame_l     <= '0;
            r_frame_r     <= '0;
            r_ready       <= 1'b0;
            r_lr          <= CH_LEFT;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            // Registered form of !full || load, looking one cycle ahead
            r_ready       <= !w_full_next || w_load_pre;
            r_full        <= w_full_next;
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_full;
            if (w_load) begin
                r_frame_l <= r_full ? r_pend_l : '0;
                r_frame_r <= r_full ? r_pend_r : '0;
            end
            if (w_accept) begin
                r_pend_l <= sample_l_i;
                r_pend_r <= sample_r_i;
            end
            if (w_bck_fall) begin
                r_lr    <= w_right_next ? CH_RIGHT : CH_LEFT;
                r_sdata <= w_sdata_next;
            end
        end
    end

    assign sample_ready_o = r_ready;
    assign ASCLK_o        = w_sclk;
    assign ALRCLK_o       = (r_lr == CH_RIGHT);
    assign ASDATA_o       = r_sdata;
    assign frame_start_o  = r_frame_start;
    assign underrun_o     = r_underrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomized bench: an I2S receiver model decodes the serial stream and compares frames with a transaction-level queue.
module tb_i2s_tx_serializer;

    localparam int unsigned SLOT = 32;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    typedef enum int {M_IDLE, M_ONESHOT, M_CONT, M_RAND} mode_e;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] drv_l = '0;
    logic [23:0] drv_r = '0;

    logic rdy1, sclk1, lr1, sd1, fs1, ur1;
    logic rdy2, sclk2, lr2, sd2, fs2, ur2;

    always #5 clk = ~clk;

    i2s_tx_serializer u_dut (
        .AMCLK_i        (clk),
        .nARST          (rst_n),
        .sample_l_i     (drv_l),
        .sample_r_i     (drv_r),
        .sample_valid_i (valid & ~sel),
        .sample_ready_o (rdy1),
        .ASCLK_o        (sclk1),
        .ALRCLK_o       (lr1),
        .ASDATA_o       (sd1),
        .frame_start_o  (fs1),
        .underrun_o     (ur1)
    );

    i2s_tx_serializer #(
        .SAMPLE_WIDTH (16),
        .SLOT_WIDTH   (32),
        .MCLK_DIV     (2)
    ) u_dut16 (
        .AMCLK_i        (clk),
        .nARST          (rst_n),
        .sample_l_i     (drv_l[15:0]),
        .sample_r_i     (drv_r[15:0]),
        .sample_valid_i (valid & sel),
        .sample_ready_o (rdy2),
        .ASCLK_o        (sclk2),
        .ALRCLK_o       (lr2),
        .ASDATA_o       (sd2),
        .frame_start_o  (fs2),
        .underrun_o     (ur2)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned div = 4;
    int unsigned sw = 24;
    int unsigned frame = 256;
    int unsigned k = 0;
    bit          in_rst = 1'b1;
    mode_e       mode = M_IDLE;
    logic [23:0] os_l = '0;
    logic [23:0] os_r = '0;
    bit          os_pend = 1'b0;
    logic [23:0] cnt = 24'h000100;

    pair_t       exp_q[$];
    bit          m_full = 1'b0;
    pair_t       m_pend = '0;
    bit          exp_fs = 1'b0;
    bit          exp_ur = 1'b0;
    bit          last_acc = 1'b1;
    int unsigned n_bit = 0;
    logic [31:0] sh = '0;
    logic [31:0] left_slot = '0;
    logic        p_sclk = 1'b0;
    logic        p_lr = 1'b0;
    logic        p_sd = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] mask_w(input logic [23:0] x);
        logic [31:0] m;
        m = (32'd1 << sw) - 32'd1;
        return x & m[23:0];
    endfunction

    // I2S slot as seen on the wire: one leading 0, MSB-first sample, zero padding
    function automatic logic [31:0] slot_of(input logic [23:0] x);
        logic [31:0] v;
        v = {8'd0, mask_w(x)};
        return v << (SLOT - 1 - sw);
    endfunction

    task automatic pick_new();
        case (mode)
            M_ONESHOT: begin
                valid = os_pend;
                if (os_pend) begin
                    drv_l   = os_l;
                    drv_r   = os_r;
                    os_pend = 1'b0;
                end
            end
            M_CONT: begin
                valid = 1'b1;
                drv_l = cnt;
                drv_r = ~cnt;
                cnt   = cnt + 24'd1;
            end
            M_RAND: begin
                valid = ($urandom_range(0, 2) == 0);
                drv_l = 24'($urandom);
                drv_r = 24'($urandom);
            end
            default: valid = 1'b0;
        endcase
    endtask

    // Monitor, receiver model and stimulus driver, all away from the active edge
    initial begin
        logic        o_rdy, o_sclk, o_lr, o_sd, o_fs, o_ur;
        bit          ready_k, acc, load;
        pair_t       e;
        forever begin
            @(negedge clk);
            o_rdy  = sel ? rdy2  : rdy1;
            o_sclk = sel ? sclk2 : sclk1;
            o_lr   = sel ? lr2   : lr1;
            o_sd   = sel ? sd2   : sd1;
            o_fs   = sel ? fs2   : fs1;
            o_ur   = sel ? ur2   : ur1;
            if (!rst_n) begin
                in_rst   = 1'b1;
                k        = 0;
                m_full   = 1'b0;
                exp_fs   = 1'b0;
                exp_ur   = 1'b0;
                last_acc = 1'b1;
                n_bit    = 0;
                valid    = 1'b0;
                exp_q.delete();
                exp_q.push_back('0);
                check_eq("rst_out", 32'({o_rdy, o_sclk, o_lr, o_sd, o_fs, o_ur}), 32'd0);
            end else begin
                if (in_rst) begin
                    in_rst = 1'b0;
                    k = 0;
                end else begin
                    k++;
                end
                check_eq("asclk", 32'(o_sclk), 32'((k % div) >= (div / 2)));
                check_eq("frame_start", 32'(o_fs), 32'(exp_fs));
                check_eq("underrun", 32'(o_ur), 32'(exp_ur));
                if (o_lr !== p_lr || o_sd !== p_sd) begin
                    check_eq("edge_align", 32'({p_sclk, o_sclk}), 32'b10);
                end
                if (!p_sclk && o_sclk) begin
                    check_eq("alrclk", 32'(o_lr), 32'(n_bit >= SLOT));
                    sh = {sh[30:0], o_sd};
                    if (n_bit == SLOT - 1) left_slot = sh;
                    if (n_bit == 2 * SLOT - 1) begin
                        if (exp_q.size() == 0) begin
                            check_eq("frame_q", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("slot_l", left_slot, slot_of(e.l));
                            check_eq("slot_r", sh, slot_of(e.r));
                        end
                    end
                    n_bit = (n_bit + 1) % (2 * SLOT);
                end
                ready_k = (k != 0) && (!m_full || ((k + 1) % frame == 0));
                check_eq("ready", 32'(o_rdy), 32'(ready_k));
                if (!valid || last_acc) pick_new();
                acc  = valid && ready_k;
                load = ((k + 1) % frame == 0);
                exp_fs = load;
                exp_ur = load && !m_full;
                if (load) begin
                    exp_q.push_back(m_full ? m_pend : pair_t'('0));
                    m_full = acc;
                end else if (acc) begin
                    m_full = 1'b1;
                end
                if (acc) m_pend = '{l: mask_w(drv_l), r: mask_w(drv_r)};
                last_acc = acc;
            end
            p_sclk = o_sclk;
            p_lr   = o_lr;
            p_sd   = o_sd;
        end
    end

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(rdy1), 32'd0);
        check_eq("rst_asclk", 32'(sclk1), 32'd0);
        check_eq("rst_alrclk", 32'(lr1), 32'd0);
        check_eq("rst_asdata", 32'(sd1), 32'd0);

        os_l = 24'h800001;
        os_r = 24'h7FFFFE;
        os_pend = 1'b1;
        mode = M_ONESHOT;
        rst_n = 1'b1;
        repeat (3 * frame) @(posedge clk);
        #1 mode = M_CONT;
        repeat (5 * frame) @(posedge clk);
        #1 mode = M_RAND;
        repeat (5 * frame) @(posedge clk);
        #1 mode = M_CONT;
        repeat (frame) @(posedge clk);

        hit = 1'b0;
        for (int i = 0; i < 2 * int'(frame) && !hit; i++) begin
            @(posedge clk);
            #1;
            if (((k + 1) % frame) == 40 * div + 1) hit = 1'b1;
        end
        check_eq("b40_reach", 32'(hit), 32'd1);
        check_eq("pre_rst_alrclk", 32'(lr1), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out", 32'({rdy1, sclk1, lr1, sd1, fs1, ur1}), 32'd0);
        repeat (3) @(posedge clk);
        #1 mode = M_IDLE;
        rst_n = 1'b1;
        repeat (2 * frame + 4) @(posedge clk);

        #1 rst_n = 1'b0;
        sel = 1'b1;
        div = 2;
        sw = 16;
        frame = 128;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst16_out", 32'({rdy2, sclk2, lr2, sd2, fs2, ur2}), 32'd0);
        os_l = 24'h008001;
        os_r = 24'h007FFE;
        os_pend = 1'b1;
        mode = M_ONESHOT;
        rst_n = 1'b1;
        repeat (2 * frame) @(posedge clk);
        #1 mode = M_RAND;
        repeat (4 * frame) @(posedge clk);
        #1 mode = M_CONT;
        repeat (2 * frame) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
